vending_machine_multi: RTL and testbench

//  Parametrised vending controller: N drinks with per-drink price table, coin validation, credit

---
 rtl/vending_machine_multi.sv | 217 +++++++++++++++++++++
 tb/tb_vending_machine_multi.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : vending_machine_multi
// Description : Multi-drink vending controller: coin validation, credit,
//               selection, cancel/refund and change. Define STOCK_COUNT_EN
//               to enable per-drink stock counters and sold-out reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_multi #(
    parameter int NUM_DRINKS = 4,
    parameter int SEL_W      = 3,
    parameter int COIN_W     = 6,
    parameter int CREDIT_W   = 8,
    parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICE_LIST = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int MAX_CREDIT = 200,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COIN_W-1:0]     coin,
    input  logic                  coin_valid,
    input  logic [SEL_W-1:0]      drink_choose,
    input  logic                  cancel,
    input  logic                  restock,
    output logic [CREDIT_W-1:0]   credit,
    output logic [NUM_DRINKS-1:0] available,
    output logic [NUM_DRINKS-1:0] sold_out,
    output logic                  dispense,
    output logic [SEL_W-1:0]      dispense_id,
    output logic [CREDIT_W-1:0]   change,
    output logic                  change_valid,
    output logic                  coin_reject,
    output logic                  sel_error
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_REFUND   = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0] c_max_credit = MAX_CREDIT[CREDIT_W:0];

    state_t                r_state, w_state_nxt;
    logic [CREDIT_W-1:0]   r_credit, w_credit_nxt;
    logic                  r_dispense, w_dispense_nxt;
    logic [SEL_W-1:0]      r_dispense_id, w_dispense_id_nxt;
    logic [CREDIT_W-1:0]   r_change, w_change_nxt;
    logic                  r_change_valid, w_change_valid_nxt;
    logic                  r_coin_reject, w_coin_reject_nxt;
    logic                  r_sel_error, w_sel_error_nxt;
    logic [SEL_W-1:0]      r_last_sel, w_last_sel_nxt;
    logic [NUM_DRINKS-1:0] w_stock_dec;
    logic [NUM_DRINKS-1:0] w_in_stock;

    logic [CREDIT_W-1:0]   w_price [NUM_DRINKS];
    logic [CREDIT_W:0]     w_coin_ext;
    logic [CREDIT_W:0]     w_credit_sum;
    logic                  w_coin_legal;
    logic                  w_coin_ok;
    logic                  w_sel_known;
    logic [CREDIT_W-1:0]   w_sel_price;
    logic                  w_sel_stock;
    logic [NUM_DRINKS-1:0] w_sel_onehot;
    logic                  w_sel_req;
    logic                  w_sel_ok;

    for (genvar gi = 0; gi < NUM_DRINKS; gi++) begin : g_price
        assign w_price[gi]   = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
        assign available[gi] = (r_credit >= w_price[gi]) && w_in_stock[gi];
    end

`ifdef STOCK_COUNT_EN
    localparam logic [STOCK_W-1:0] c_stock_init = STOCK_W'(STOCK_INIT);

    for (genvar gi = 0; gi < NUM_DRINKS; gi++) begin : g_stock
        logic [STOCK_W-1:0] r_stock;
        // Reload has priority over a same-cycle decrement.
        always_ff @(posedge clk) begin
            if (reset || restock) begin
                r_stock <= c_stock_init;
            end else if (w_stock_dec[gi] && (r_stock != '0)) begin
                r_stock <= r_stock - STOCK_W'(1);
            end
        end
        assign w_in_stock[gi] = (r_stock != '0);
    end
    assign sold_out = ~w_in_stock;
`else
    logic w_unused_stock;
    assign w_unused_stock = ^{restock, w_stock_dec};
    assign w_in_stock     = '1;
    assign sold_out       = '0;
`endif

    assign w_coin_ext   = (CREDIT_W+1)'(coin);
    assign w_credit_sum = {1'b0, r_credit} + w_coin_ext;
    assign w_coin_legal = (coin == COIN_W'(1))  || (coin == COIN_W'(5)) ||
                          (coin == COIN_W'(10)) || (coin == COIN_W'(50));
    assign w_coin_ok    = w_coin_legal && (w_credit_sum <= c_max_credit);

    always_comb begin
        w_sel_known  = 1'b0;
        w_sel_price  = '0;
        w_sel_stock  = 1'b0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (drink_choose == SEL_W'(i + 1)) begin
                w_sel_known     = 1'b1;
                w_sel_price     = w_price[i];
                w_sel_stock     = w_in_stock[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // A held code is acted on once; a new code, release to 0 or an accepted coin re-arms it.
    assign w_sel_req = (r_state == S_CREDIT) && (drink_choose != '0) &&
                       (drink_choose != r_last_sel);
    assign w_sel_ok  = w_sel_known && (r_credit >= w_sel_price) && w_sel_stock;

    always_comb begin
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_dispense_nxt     = 1'b0;
        w_dispense_id_nxt  = '0;
        w_change_nxt       = '0;
        w_change_valid_nxt = 1'b0;
        w_coin_reject_nxt  = 1'b0;
        w_sel_error_nxt    = 1'b0;
        w_stock_dec        = '0;
        w_last_sel_nxt     = (drink_choose == '0) ? '0 : r_last_sel;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                if ((r_state == S_CREDIT) && cancel) begin
                    w_state_nxt        = S_REFUND;
                    w_change_nxt       = r_credit;
                    w_change_valid_nxt = 1'b1;
                    w_credit_nxt       = '0;
                    w_coin_reject_nxt  = coin_valid;
                end else if (w_sel_req) begin
                    w_last_sel_nxt    = drink_choose;
                    w_coin_reject_nxt = coin_valid;
                    if (w_sel_ok) begin
                        w_state_nxt       = S_DISPENSE;
                        w_credit_nxt      = r_credit - w_sel_price;
                        w_dispense_nxt    = 1'b1;
                        w_dispense_id_nxt = drink_choose;
                        w_stock_dec       = w_sel_onehot;
                    end else begin
                        w_sel_error_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (w_coin_ok) begin
                        w_credit_nxt   = w_credit_sum[CREDIT_W-1:0];
                        w_state_nxt    = S_CREDIT;
                        w_last_sel_nxt = '0;
                    end else begin
                        w_coin_reject_nxt = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                w_coin_reject_nxt = coin_valid;
                if (r_credit != '0) begin
                    w_state_nxt        = S_REFUND;
                    w_change_nxt       = r_credit;
                    w_change_valid_nxt = 1'b1;
                    w_credit_nxt       = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_coin_reject_nxt = coin_valid;
                w_state_nxt       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_dispense     <= 1'b0;
            r_dispense_id  <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sel_error    <= 1'b0;
            r_last_sel     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_dispense     <= w_dispense_nxt;
            r_dispense_id  <= w_dispense_id_nxt;
            r_change       <= w_change_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
            r_sel_error    <= w_sel_error_nxt;
            r_last_sel     <= w_last_sel_nxt;
        end
    end

    assign credit       = r_credit;
    assign dispense     = r_dispense;
    assign dispense_id  = r_dispense_id;
    assign change       = r_change;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;
    assign sel_error    = r_sel_error;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_machine_multi
// Description : Directed and random checks of vending_machine_multi against a
//               credit-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

    localparam int NUM_DRINKS = 4;
    localparam int SEL_W      = 3;
    localparam int COIN_W     = 6;
    localparam int CREDIT_W   = 8;
`ifdef STOCK_COUNT_EN
    localparam int STOCK_INIT = 1;
    localparam bit HAS_STOCK  = 1'b1;
`else
    localparam int STOCK_INIT = 8;
    localparam bit HAS_STOCK  = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic [COIN_W-1:0]     coin;
    logic                  coin_valid;
    logic [SEL_W-1:0]      drink_choose;
    logic                  cancel;
    logic                  restock;
    logic [CREDIT_W-1:0]   credit;
    logic [NUM_DRINKS-1:0] available;
    logic [NUM_DRINKS-1:0] sold_out;
    logic                  dispense;
    logic [SEL_W-1:0]      dispense_id;
    logic [CREDIT_W-1:0]   change;
    logic                  change_valid;
    logic                  coin_reject;
    logic                  sel_error;

    vending_machine_multi #(
        .NUM_DRINKS (NUM_DRINKS),
        .SEL_W      (SEL_W),
        .COIN_W     (COIN_W),
        .CREDIT_W   (CREDIT_W),
        .PRICE_LIST ({8'd25, 8'd20, 8'd15, 8'd10}),
        .MAX_CREDIT (200),
        .STOCK_W    (4),
        .STOCK_INIT (STOCK_INIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .coin         (coin),
        .coin_valid   (coin_valid),
        .drink_choose (drink_choose),
        .cancel       (cancel),
        .restock      (restock),
        .credit       (credit),
        .available    (available),
        .sold_out     (sold_out),
        .dispense     (dispense),
        .dispense_id  (dispense_id),
        .change       (change),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .sel_error    (sel_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: credit in plain integers, phase 0 = taking coins/selections,
    // 1 = drink just released, 2 = refund just paid out.
    int price [1:4] = '{10, 15, 20, 25};
    int m_credit, m_phase, m_blocked;
    int m_stock [1:4];
    int e_disp, e_id, e_chg, e_cv, e_rej, e_se, e_avail, e_sold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int ch;
        int cv;
        ch = int'(drink_choose);
        e_disp = 0; e_id = 0; e_chg = 0; e_cv = 0; e_rej = 0; e_se = 0;
        if (reset) begin
            m_credit = 0; m_phase = 0; m_blocked = 0;
            for (int d = 1; d <= 4; d++) m_stock[d] = STOCK_INIT;
        end else begin
            cv = coin_valid ? 1 : 0;
            if (ch == 0) m_blocked = 0;
            if (m_phase == 1) begin
                e_rej = cv;
                if (m_credit > 0) begin
                    e_chg = m_credit; e_cv = 1; m_credit = 0; m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end else if (m_phase == 2) begin
                e_rej = cv;
                m_phase = 0;
            end else if (cancel && m_credit > 0) begin
                e_chg = m_credit; e_cv = 1; m_credit = 0; m_phase = 2; e_rej = cv;
            end else if (m_credit > 0 && ch != 0 && ch != m_blocked) begin
                m_blocked = ch;
                e_rej = cv;
                if (ch <= NUM_DRINKS && m_credit >= price[ch] &&
                    (!HAS_STOCK || m_stock[ch] > 0)) begin
                    m_credit -= price[ch];
                    e_disp = 1; e_id = ch; m_phase = 1;
                    if (HAS_STOCK) m_stock[ch]--;
                end else begin
                    e_se = 1;
                end
            end else if (coin_valid) begin
                if ((coin == 1 || coin == 5 || coin == 10 || coin == 50) &&
                    (m_credit + int'(coin) <= 200)) begin
                    m_credit += int'(coin);
                    m_blocked = 0;
                end else begin
                    e_rej = 1;
                end
            end
            if (HAS_STOCK && restock)
                for (int d = 1; d <= 4; d++) m_stock[d] = STOCK_INIT;
        end
        e_avail = 0; e_sold = 0;
        for (int d = 1; d <= 4; d++) begin
            if (m_credit >= price[d] && (!HAS_STOCK || m_stock[d] > 0)) e_avail |= (1 << (d - 1));
            if (HAS_STOCK && m_stock[d] == 0) e_sold |= (1 << (d - 1));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("credit",       32'(credit),       32'(m_credit));
        chk("available",    32'(available),    32'(e_avail));
        chk("sold_out",     32'(sold_out),     32'(e_sold));
        chk("dispense",     32'(dispense),     32'(e_disp));
        chk("dispense_id",  32'(dispense_id),  32'(e_id));
        chk("change",       32'(change),       32'(e_chg));
        chk("change_valid", 32'(change_valid), 32'(e_cv));
        chk("coin_reject",  32'(coin_reject),  32'(e_rej));
        chk("sel_error",    32'(sel_error),    32'(e_se));
    endtask

    task automatic drive(input logic cv, input logic [COIN_W-1:0] c, input logic [SEL_W-1:0] ch,
                         input logic can, input logic rs);
        reset = 1'b0; coin_valid = cv; coin = c; drink_choose = ch; cancel = can; restock = rs;
        cycle();
    endtask

    initial begin
        reset = 1'b1; coin = '0; coin_valid = 1'b0; drink_choose = '0; cancel = 1'b0; restock = 1'b0;
        cycle();
        cycle();
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_pulses", 32'({dispense, change_valid, coin_reject, sel_error}), 32'd0);

        // Coin accumulation and affordability
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0); chk("c10", 32'(credit), 32'd10); chk("a10", 32'(available), 32'b0001);
        drive(1'b1, 6'd5,  3'd0, 1'b0, 1'b0); chk("c15", 32'(credit), 32'd15); chk("a15", 32'(available), 32'b0011);
        drive(1'b1, 6'd1,  3'd0, 1'b0, 1'b0); chk("c16", 32'(credit), 32'd16); chk("a16", 32'(available), 32'b0011);
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0); chk("c26", 32'(credit), 32'd26); chk("a26", 32'(available), 32'b1111);

        // Purchase with change
        drive(1'b0, 6'd0, 3'd3, 1'b0, 1'b0);
        chk("buy3_disp", 32'(dispense), 32'd1); chk("buy3_id", 32'(dispense_id), 32'd3);
        chk("buy3_credit", 32'(credit), 32'd6);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
        chk("buy3_change", 32'(change), 32'd6); chk("buy3_cv", 32'(change_valid), 32'd1);
        chk("buy3_zero", 32'(credit), 32'd0);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);

        // Selection errors
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd2, 1'b0, 1'b0);
        chk("short_se", 32'(sel_error), 32'd1); chk("short_credit", 32'(credit), 32'd10);
        drive(1'b0, 6'd0, 3'd7, 1'b0, 1'b0);
        chk("bad_code_se", 32'(sel_error), 32'd1);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);

        // Coin rejection: illegal value and credit ceiling
        drive(1'b1, 6'd3, 3'd0, 1'b0, 1'b0);
        chk("coin3_rej", 32'(coin_reject), 32'd1); chk("coin3_credit", 32'(credit), 32'd10);
        for (int k = 0; k < 3; k++) drive(1'b1, 6'd50, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        chk("c190", 32'(credit), 32'd190);
        drive(1'b1, 6'd50, 3'd0, 1'b0, 1'b0);
        chk("max_rej", 32'(coin_reject), 32'd1); chk("max_credit", 32'(credit), 32'd190);
        drive(1'b0, 6'd0, 3'd0, 1'b1, 1'b0);
        chk("cancel190", 32'(change), 32'd190);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);

        // Cancel beats a same-cycle coin; cancel in IDLE does nothing
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 6'd5,  3'd0, 1'b0, 1'b0);
        drive(1'b1, 6'd10, 3'd0, 1'b1, 1'b0);
        chk("cxl_change", 32'(change), 32'd15); chk("cxl_rej", 32'(coin_reject), 32'd1);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd0, 1'b1, 1'b0);
        chk("idle_cxl_cv", 32'(change_valid), 32'd0);

        // Held selection is not repeated without a fresh coin
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 6'd5,  3'd0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd2, 1'b0, 1'b0);
        chk("hold_first", 32'(dispense), 32'd1);
        drive(1'b0, 6'd0, 3'd2, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd2, 1'b0, 1'b0);
        chk("hold_idle", 32'(dispense), 32'd0);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);

`ifdef STOCK_COUNT_EN
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd1, 1'b0, 1'b0);
        chk("stk_buy1", 32'(dispense), 32'd1);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
        chk("stk_sold", 32'(sold_out[0]), 32'd1);
        drive(1'b1, 6'd10, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 3'd1, 1'b0, 1'b0);
        chk("stk_se", 32'(sel_error), 32'd1);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b1);
        chk("stk_restock", 32'(sold_out[0]), 32'd0);
        drive(1'b0, 6'd0, 3'd0, 1'b1, 1'b0);
        drive(1'b0, 6'd0, 3'd0, 1'b0, 1'b0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            coin_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       coin = 6'd1;
                1:       coin = 6'd5;
                2, 3:    coin = 6'd10;
                4:       coin = 6'd50;
                5:       coin = 6'd3;
                6:       coin = 6'd0;
                default: coin = 6'd25;
            endcase
            if ($urandom_range(0, 3) == 0) drink_choose = 3'($urandom_range(0, 7));
            cancel  = ($urandom_range(0, 19) == 0);
            restock = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
